fetch_stage: RTL

- IF stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. It sits directly upstream of the hazard/forwarding unit.
- Holds PC_F and drives the instruction-memory address.
- Registers the fetched word into InsD, which the hazard unit and decoder consume.
- Computes the next PC from the instruction in D (beq/j/jal/jr, one architectural delay slot), and obeys the hazard unit's stall.

---
 rtl/fetch_stage.sv | 81 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: holds PC_F, picks the next PC from the
// instruction in D (beq/j/jal/jr with one delay slot) and honours the hazard stall.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        cmp_equal,
  input  logic [31:0] rs_fwd,
  input  logic [31:0] im_data,
  output logic [31:0] im_addr,
  output logic [31:0] InsD,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        exc_D
);

  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

  logic [31:0] pc_f;
  logic [31:0] pc_next;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        is_beq;
  logic        is_jump;
  logic        is_jr;
  logic        fetch_legal;

  assign opcode  = InsD[31:26];
  assign funct   = InsD[5:0];
  assign is_beq  = (opcode == 6'b000100);
  assign is_jump = (opcode == 6'b000010) || (opcode == 6'b000011);
  assign is_jr   = (opcode == 6'b000000) && (funct == 6'b001000);

  assign branch_offset = {{14{InsD[15]}}, InsD[15:0], 2'b00};
  assign branch_target = PC_D + 32'd4 + branch_offset;
  // The 256MB region comes from PC_D rather than the delay slot's PC.
  assign jump_target   = {PC_D[31:28], InsD[25:0], 2'b00};

  assign fetch_legal = (pc_f[1:0] == 2'b00) && (pc_f >= PC_RESET) && (pc_f <= PC_LAST);

  always_comb begin
    pc_next = pc_f + 32'd4;
    if (is_beq && cmp_equal) begin
      pc_next = branch_target;
    end else if (is_jump) begin
      pc_next = jump_target;
    end else if (is_jr) begin
      pc_next = rs_fwd;
    end
  end

  // Stall freezes both PC_F and IF/ID, so a redirect pending in D is retaken on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f  <= PC_RESET;
      InsD  <= 32'h0;
      PC_D  <= 32'h0;
      exc_D <= 1'b0;
    end else if (!stall) begin
      pc_f <= pc_next;
      PC_D <= pc_f;
      if (fetch_legal) begin
        InsD  <= im_data;
        exc_D <= 1'b0;
      end else begin
        InsD  <= 32'h0;
        exc_D <= 1'b1;
      end
    end
  end

  assign im_addr = pc_f;
  assign PC8_D   = PC_D + 32'd8;

endmodule
